// File: rtl/sw_pkg.sv
// Shared constants and FSM encoding for the Smith-Waterman systolic array controller.
package sw_pkg;

    localparam int unsigned SCORE_WIDTH = 11;

    localparam logic [1:0] N_A = 2'd0;
    localparam logic [1:0] N_G = 2'd1;
    localparam logic [1:0] N_T = 2'd2;
    localparam logic [1:0] N_C = 2'd3;

    // Score the array reports for "no alignment"; all PE scores are offset by this.
    localparam int unsigned NEUTRAL = 32'h400;

    typedef enum logic [2:0] {
        StIdle,
        StArst,
        StLoad,
        StStream,
        StDrain,
        StDone
    } sw_state_e;

endpackage

// File: rtl/sw_ctrl_capture.sv
// Drain-phase result capture: latches the last-PE high score, removes the bias and
// flags completion or a drain timeout of LENGTH+4 cycles.
module sw_ctrl_capture
    import sw_pkg::*;
#(
    parameter int unsigned LENGTH      = 48,
    parameter int unsigned SCORE_WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   drain_i,
    input  logic                   lvld_i,
    input  logic [SCORE_WIDTH-1:0] high_i,
    output logic                   done_o,
    output logic                   timeout_o,
    output logic [SCORE_WIDTH-1:0] score_o
);

    localparam int unsigned TmoCycles = LENGTH + 4;
    localparam int unsigned CntW      = $clog2(TmoCycles + 1);
    localparam logic [SCORE_WIDTH-1:0] Bias = SCORE_WIDTH'(NEUTRAL);

    logic [SCORE_WIDTH-1:0] high_q;
    logic                   seen_q;
    logic [CntW-1:0]        cnt_q;

    // State only lives while draining, so every job starts from a clean capture.
    always_ff @(posedge clk) begin
        if (i_rst || !drain_i) begin
            high_q <= '0;
            seen_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
            if (lvld_i) begin
                high_q <= high_i;
                seen_q <= 1'b1;
            end
        end
    end

    assign done_o    = drain_i && seen_q && !lvld_i;
    assign timeout_o = drain_i && !done_o && (cnt_q == CntW'(TmoCycles - 1));
    assign score_o   = (high_q > Bias) ? (high_q - Bias) : '0;

endmodule

// File: rtl/sw_array_ctrl.sv
// Job sequencer for the Smith-Waterman systolic array: array reset, query preload,
// gap-free target stream, drain and result hand-off. SW_CTRL_CYCLE_CNT_EN adds o_cycles.
module sw_array_ctrl
    import sw_pkg::*;
#(
    parameter int unsigned LENGTH      = 48,
    parameter int unsigned SCORE_WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_local,
    input  logic [15:0]            i_tlen,
    input  logic [1:0]             i_q_data,
    input  logic                   i_q_vld,
    output logic                   o_q_rdy,
    input  logic [1:0]             i_t_data,
    input  logic                   i_t_vld,
    output logic                   o_t_rdy,
    output logic                   o_arr_rst,
    output logic                   o_arr_pl_en,
    output logic [1:0]             o_arr_pl_data,
    output logic [1:0]             o_arr_data,
    output logic                   o_arr_vld,
    output logic                   o_arr_local,
    input  logic [SCORE_WIDTH-1:0] i_arr_high,
    input  logic                   i_arr_lvld,
    output logic                   o_busy,
    output logic [SCORE_WIDTH-1:0] o_score,
    output logic                   o_err,
    output logic                   o_score_vld,
    input  logic                   i_score_rdy
`ifdef SW_CTRL_CYCLE_CNT_EN
    ,
    output logic [31:0]            o_cycles
`endif
);

    localparam int unsigned QCntW = $clog2(LENGTH + 1);

    sw_state_e              state_q;
    logic                   arr_rst_q;
    logic                   arst_cnt_q;
    logic                   q_rdy_q;
    logic                   t_rdy_q;
    logic                   busy_q;
    logic                   local_q;
    logic                   err_q;
    logic                   score_vld_q;
    logic [15:0]            tlen_q;
    logic [15:0]            t_cnt_q;
    logic [QCntW-1:0]       q_cnt_q;
    logic [SCORE_WIDTH-1:0] score_q;

    logic                   q_hs;
    logic                   t_hs;
    logic                   drain;
    logic                   cap_done;
    logic                   cap_timeout;
    logic [SCORE_WIDTH-1:0] cap_score;

    assign q_hs  = i_q_vld && q_rdy_q;
    assign t_hs  = i_t_vld && t_rdy_q;
    assign drain = (state_q == StDrain);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            arr_rst_q   <= 1'b0;
            arst_cnt_q  <= 1'b0;
            q_rdy_q     <= 1'b0;
            t_rdy_q     <= 1'b0;
            busy_q      <= 1'b0;
            local_q     <= 1'b0;
            err_q       <= 1'b0;
            score_vld_q <= 1'b0;
            tlen_q      <= '0;
            t_cnt_q     <= '0;
            q_cnt_q     <= '0;
            score_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_q    <= StArst;
                        tlen_q     <= i_tlen;
                        local_q    <= i_local;
                        busy_q     <= 1'b1;
                        arr_rst_q  <= 1'b1;
                        arst_cnt_q <= 1'b0;
                        err_q      <= 1'b0;
                        score_q    <= '0;
                    end
                end
                StArst: begin
                    arst_cnt_q <= 1'b1;
                    if (arst_cnt_q) begin
                        arr_rst_q <= 1'b0;
                        q_rdy_q   <= 1'b1;
                        q_cnt_q   <= '0;
                        state_q   <= StLoad;
                    end
                end
                StLoad: begin
                    if (q_hs) begin
                        q_cnt_q <= q_cnt_q + QCntW'(1);
                        if (q_cnt_q == QCntW'(LENGTH - 1)) begin
                            q_rdy_q <= 1'b0;
                            if (tlen_q == 16'd0) begin
                                score_vld_q <= 1'b1;
                                state_q     <= StDone;
                            end else begin
                                t_rdy_q <= 1'b1;
                                t_cnt_q <= '0;
                                state_q <= StStream;
                            end
                        end
                    end
                end
                StStream: begin
                    if (t_hs) begin
                        t_cnt_q <= t_cnt_q + 16'd1;
                        if (t_cnt_q == tlen_q - 16'd1) begin
                            t_rdy_q <= 1'b0;
                            state_q <= StDrain;
                        end
                    end else begin
                        // A bubble would corrupt the wavefront in the array; abort the job.
                        t_rdy_q     <= 1'b0;
                        err_q       <= 1'b1;
                        score_vld_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDrain: begin
                    if (cap_done) begin
                        score_q     <= cap_score;
                        score_vld_q <= 1'b1;
                        state_q     <= StDone;
                    end else if (cap_timeout) begin
                        err_q       <= 1'b1;
                        score_vld_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (i_score_rdy) begin
                        score_vld_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    sw_ctrl_capture #(
        .LENGTH      (LENGTH),
        .SCORE_WIDTH (SCORE_WIDTH)
    ) u_capture (
        .clk       (clk),
        .i_rst     (i_rst),
        .drain_i   (drain),
        .lvld_i    (i_arr_lvld),
        .high_i    (i_arr_high),
        .done_o    (cap_done),
        .timeout_o (cap_timeout),
        .score_o   (cap_score)
    );

    assign o_q_rdy       = q_rdy_q;
    assign o_t_rdy       = t_rdy_q;
    assign o_arr_rst     = arr_rst_q || i_rst;
    assign o_arr_pl_en   = q_hs;
    assign o_arr_pl_data = q_hs ? i_q_data : 2'b00;
    assign o_arr_vld     = t_hs;
    assign o_arr_data    = t_hs ? i_t_data : 2'b00;
    assign o_arr_local   = local_q;
    assign o_busy        = busy_q;
    assign o_score       = score_q;
    assign o_err         = err_q;
    assign o_score_vld   = score_vld_q;

`ifdef SW_CTRL_CYCLE_CNT_EN
    logic [31:0] cycles_q;

    // Runs from the first ARST cycle until DONE is entered, then holds.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            cycles_q <= '0;
        end else if (state_q == StIdle) begin
            if (i_start) begin
                cycles_q <= '0;
            end
        end else if (state_q != StDone) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign o_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_sw_array_ctrl.sv
// Self-checking bench for sw_array_ctrl (LENGTH=4): behavioural array model on the array
// side, expected results queued per job and compared when o_score_vld appears.
`timescale 1ns/1ps
module tb_sw_array_ctrl;
    import sw_pkg::*;

    localparam int unsigned LEN  = 4;
    localparam int unsigned SW   = 11;
    localparam int          MAXT = 16;

    logic          clk = 1'b0;
    logic          i_rst, i_start, i_local;
    logic [15:0]   i_tlen;
    logic [1:0]    i_q_data, i_t_data;
    logic          i_q_vld, i_t_vld, i_score_rdy;
    logic          o_q_rdy, o_t_rdy, o_arr_rst, o_arr_pl_en, o_arr_vld, o_arr_local;
    logic [1:0]    o_arr_pl_data, o_arr_data;
    logic [SW-1:0] i_arr_high, o_score;
    logic          i_arr_lvld, o_busy, o_err, o_score_vld;
`ifdef SW_CTRL_CYCLE_CNT_EN
    logic [31:0]   o_cycles;
`endif

    always #5 clk = ~clk;

    sw_array_ctrl #(
        .LENGTH      (LEN),
        .SCORE_WIDTH (SW)
    ) dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_local       (i_local),
        .i_tlen        (i_tlen),
        .i_q_data      (i_q_data),
        .i_q_vld       (i_q_vld),
        .o_q_rdy       (o_q_rdy),
        .i_t_data      (i_t_data),
        .i_t_vld       (i_t_vld),
        .o_t_rdy       (o_t_rdy),
        .o_arr_rst     (o_arr_rst),
        .o_arr_pl_en   (o_arr_pl_en),
        .o_arr_pl_data (o_arr_pl_data),
        .o_arr_data    (o_arr_data),
        .o_arr_vld     (o_arr_vld),
        .o_arr_local   (o_arr_local),
        .i_arr_high    (i_arr_high),
        .i_arr_lvld    (i_arr_lvld),
        .o_busy        (o_busy),
        .o_score       (o_score),
        .o_err         (o_err),
        .o_score_vld   (o_score_vld),
`ifdef SW_CTRL_CYCLE_CNT_EN
        .o_cycles      (o_cycles),
`endif
        .i_score_rdy   (i_score_rdy)
    );

    typedef struct {
        int score;
        bit err;
        bit chk_score;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // Array scoring: match +5, mismatch -3, linear gap -4, local (floored at 0).
    function automatic int sw_ref(input logic [1:0] q[LEN], input logic [1:0] t[MAXT],
                                  input int n);
        int h[LEN+1][MAXT+1];
        int best = 0;
        for (int i = 0; i <= LEN; i++)
            for (int j = 0; j <= MAXT; j++) h[i][j] = 0;
        for (int i = 1; i <= LEN; i++) begin
            for (int j = 1; j <= n; j++) begin
                int v;
                v = h[i-1][j-1] + ((q[i-1] == t[j-1]) ? 5 : -3);
                if (h[i-1][j] - 4 > v) v = h[i-1][j] - 4;
                if (h[i][j-1] - 4 > v) v = h[i][j-1] - 4;
                if (v < 0) v = 0;
                h[i][j] = v;
                if (v > best) best = v;
            end
        end
        return best;
    endfunction

    // Array model: preload and stream captured from the DUT, results emerge LEN-1 cycles later.
    bit            arr_mute = 0;
    bit            arr_force_low = 0;
    logic [1:0]    m_q[LEN];
    logic [1:0]    m_t[MAXT];
    int            m_qn = 0;
    int            m_tn = 0;
    logic          dl_vld[LEN];
    logic [SW-1:0] dl_high[LEN];

    initial begin : arr_model
        for (int i = 0; i < LEN; i++) begin
            dl_vld[i] = 1'b0;
            dl_high[i] = '0;
        end
        i_arr_lvld = 1'b0;
        i_arr_high = '0;
        forever begin
            @(negedge clk);
            #2;
            for (int i = LEN - 1; i > 0; i--) begin
                dl_vld[i]  = dl_vld[i-1];
                dl_high[i] = dl_high[i-1];
            end
            dl_vld[0]  = 1'b0;
            dl_high[0] = '0;
            if (o_arr_rst) begin
                m_qn = 0;
                m_tn = 0;
                for (int i = 0; i < LEN; i++) dl_vld[i] = 1'b0;
            end
            if (o_arr_pl_en && m_qn < LEN) begin
                m_q[m_qn] = o_arr_pl_data;
                m_qn++;
            end
            if (o_arr_vld && m_tn < MAXT) begin
                m_t[m_tn] = o_arr_data;
                m_tn++;
                dl_vld[0]  = !arr_mute;
                dl_high[0] = arr_force_low ? SW'(NEUTRAL - 16) : SW'(NEUTRAL + sw_ref(m_q, m_t, m_tn));
            end
            i_arr_lvld = dl_vld[LEN-1];
            i_arr_high = dl_high[LEN-1];
        end
    end

    logic [1:0] qa[LEN];
    logic [1:0] ta[MAXT];

    task automatic load_q(input logic [2*LEN-1:0] v);
        for (int i = 0; i < LEN; i++) qa[i] = v[2*i +: 2];
    endtask

    task automatic load_t(input logic [2*MAXT-1:0] v);
        for (int i = 0; i < MAXT; i++) ta[i] = v[2*i +: 2];
    endtask

    task automatic run_job(input bit loc, input int tlen, input int gap_at, input int abort_at,
                           input int hold, input int exp_score, input bit exp_err,
                           input bit chk_score);
        int            qi = 0, ti = 0, cyc = 0, arst_n = 0, pl_n = 0, stable_bad = 0;
        bit            hq, ht, aborted = 0;
        exp_t          e;
        logic [SW-1:0] snap;
        logic          snap_err;
        if (abort_at < 0) begin
            e.score = exp_score;
            e.err = exp_err;
            e.chk_score = chk_score;
            sb.push_back(e);
        end
        @(negedge clk);
        i_start = 1'b1;
        i_local = loc;
        i_tlen  = 16'(tlen);
        @(negedge clk);
        i_start  = 1'b0;
        i_local  = !loc;
        i_tlen   = 16'hffff;
        i_q_vld  = 1'b1;
        i_q_data = qa[0];
        i_t_vld  = 1'b1;
        i_t_data = ta[0];
        #1;
        while (!o_score_vld && cyc < 300) begin
            arst_n += int'(o_arr_rst);
            pl_n   += int'(o_arr_pl_en);
            hq = i_q_vld && o_q_rdy;
            ht = i_t_vld && o_t_rdy;
            @(negedge clk);
            cyc++;
            if (hq) begin
                qi++;
                if (qi < LEN) i_q_data = qa[qi];
                else i_q_vld = 1'b0;
            end
            if (ht) begin
                ti++;
                i_t_data = ta[ti % MAXT];
                if (ti == gap_at) i_t_vld = 1'b0;
                if (ti == abort_at) begin
                    aborted = 1;
                    break;
                end
            end
            #1;
            if (hq && qi == LEN && tlen == 0) check_eq("tlen0_imm", o_score_vld, 1);
        end
        if (aborted) begin
            i_rst = 1'b1;
            @(negedge clk);
            #1;
            check_eq("rst_busy", o_busy, 0);
            check_eq("rst_trdy", o_t_rdy, 0);
            check_eq("rst_arr_rst", o_arr_rst, 1);
            check_eq("rst_arr_vld", o_arr_vld, 0);
            i_rst = 1'b0;
            i_q_vld = 1'b0;
            i_t_vld = 1'b0;
            return;
        end
        i_q_vld = 1'b0;
        if (gap_at >= 0) begin
            i_t_vld = 1'b1;
            #1;
            check_eq("gap_vld_drop", o_arr_vld, 0);
        end
        i_t_vld = 1'b0;
        check_eq("result_seen", o_score_vld, 1);
        if (!o_score_vld) return;
        check_eq("arst_cycles", arst_n, 2);
        check_eq("preload_cnt", pl_n, LEN);
        check_eq("arr_local", o_arr_local, loc);
        check_eq("busy_done", o_busy, 1);
        e = sb.pop_front();
        if (e.chk_score) check_eq("score", o_score, e.score);
        check_eq("err", o_err, e.err);
        snap = o_score;
        snap_err = o_err;
        for (int k = 0; k < hold; k++) begin
            if (k == 3) i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
            #1;
            if (o_score_vld !== 1'b1 || o_score !== snap || o_err !== snap_err) stable_bad++;
        end
        if (hold > 0) check_eq("hold_stable", stable_bad, 0);
        i_score_rdy = 1'b1;
        @(negedge clk);
        i_score_rdy = 1'b0;
        #1;
        check_eq("idle_busy", o_busy, 0);
        check_eq("idle_vld", o_score_vld, 0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        i_rst = 1'b1;
        i_start = 1'b0;
        i_local = 1'b0;
        i_tlen = '0;
        i_q_data = '0;
        i_q_vld = 1'b0;
        i_t_data = '0;
        i_t_vld = 1'b0;
        i_score_rdy = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_arr_rst", o_arr_rst, 1);
        check_eq("reset_busy", o_busy, 0);
        check_eq("reset_vld", o_score_vld, 0);
        check_eq("reset_qrdy", o_q_rdy, 0);
        check_eq("reset_score", o_score, 0);
        i_rst = 1'b0;
        @(negedge clk);
        #1;
        check_eq("arr_rst_release", o_arr_rst, 0);

        load_q({N_C, N_T, N_G, N_A});
        load_t({N_C, N_T, N_G, N_A});
        run_job(1, 4, -1, -1, 0, 20, 0, 1);

        load_q({N_A, N_A, N_A, N_A});
        load_t({N_C, N_C, N_C, N_C});
        run_job(1, 4, -1, -1, 0, 0, 0, 1);

        load_q({N_C, N_T, N_G, N_A});
        load_t({N_C, N_T, N_G, N_A});
        run_job(0, 4, 2, -1, 0, 0, 1, 0);

        load_t({N_C, N_C, N_G, N_A});
        run_job(1, 4, -1, -1, 10, sw_ref(qa, ta, 4), 0, 1);

        load_t({N_C, N_T, N_G, N_A});
        run_job(1, 4, -1, 2, 0, 0, 0, 0);
        run_job(1, 4, -1, -1, 0, 20, 0, 1);

        run_job(1, 0, -1, -1, 0, 0, 0, 1);

        arr_mute = 1;
        run_job(1, 4, -1, -1, 0, 0, 1, 0);
        arr_mute = 0;

        arr_force_low = 1;
        run_job(1, 4, -1, -1, 0, 0, 0, 1);
        arr_force_low = 0;

        load_t({N_A});
        run_job(1, 1, -1, -1, 0, 5, 0, 1);

        for (int r = 0; r < 4; r++) begin
            n = int'($urandom_range(2, 10));
            for (int i = 0; i < LEN; i++) qa[i] = 2'($urandom_range(0, 3));
            for (int i = 0; i < MAXT; i++) ta[i] = 2'($urandom_range(0, 3));
            run_job(1, n, -1, -1, 0, sw_ref(qa, ta, n), 0, 1);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sw_array_ctrl.md
SW_ARRAY_CTRL -- requirements
Module: sw_array_ctrl

Interface
REQ-001 SHALL have parameter LENGTH, default 48: number of PEs in the systolic array.
REQ-002 SHALL have parameter SCORE_WIDTH, default 11: score width, matching the array.
REQ-003 SHALL have ports, in this order:
- clk  in  1  clock.
- i_rst  in  1  reset: synchronous, active-high, sampled on clk.
- i_start  in  1  job start pulse.
- i_local  in  1  1 = local alignment, 0 = global; sampled with i_start.
- i_tlen  in  16  target length in characters; sampled with i_start.
- i_q_data  in  2  query nucleotide.
- i_q_vld  in  1  query character valid.
- o_q_rdy  out  1  query character accepted.
- i_t_data  in  2  target nucleotide.
- i_t_vld  in  1  target character valid.
- o_t_rdy  out  1  target character accepted.
- o_arr_rst  out  1  array reset.
- o_arr_pl_en  out  1  preload shift enable.
- o_arr_pl_data  out  2  preload character.
- o_arr_data  out  2  stream character to PE0.
- o_arr_vld  out  1  stream valid to PE0.
- o_arr_local  out  1  local-mode bit to all PEs.
- i_arr_high  in  SCORE_WIDTH  o_high of the last PE.
- i_arr_lvld  in  1  o_vld of the last PE.
- o_busy  out  1  job in progress.
- o_score  out  SCORE_WIDTH  result, de-biased.
- o_err  out  1  job aborted; valid with o_score_vld.
- o_score_vld  out  1  result valid.
- i_score_rdy  in  1  result accepted.

Function
REQ-004 SHALL implement FSM IDLE -> ARST -> LOAD -> STREAM -> DRAIN -> DONE -> IDLE.
REQ-005 IDLE: o_busy=0; i_start=1 latches i_local and i_tlen and moves to ARST.
REQ-006 i_start SHALL be ignored in every state other than IDLE.
REQ-007 ARST: o_arr_rst=1 for exactly 2 cycles, then LOAD.
REQ-008 LOAD: o_q_rdy=1; each i_q_vld&o_q_rdy handshake drives o_arr_pl_en=1 with the character on o_arr_pl_data in the same cycle.
REQ-009 LOAD SHALL last until exactly LENGTH characters are accepted, then move to STREAM; if i_tlen==0, move to DONE with o_score=0.
REQ-010 STREAM: o_t_rdy=1 and o_arr_vld=i_t_vld, with o_arr_data=i_t_data; after i_tlen characters are accepted, move to DRAIN with o_arr_vld=0.
REQ-011 The array needs gap-free valid, so i_t_vld=0 in any STREAM cycle before the last character SHALL set the error flag, drop o_arr_vld, and move to DONE.
REQ-012 DRAIN: every cycle with i_arr_lvld=1 SHALL register i_arr_high.
REQ-013 DRAIN: the first cycle with i_arr_lvld=0 after at least one cycle of 1 SHALL move to DONE.
REQ-014 DRAIN SHALL set the error flag and move to DONE after a timeout of LENGTH+4 cycles.
REQ-015 o_score SHALL be the captured high minus the neutral bias 0x400, saturated to 0 if negative.
REQ-016 DONE: o_score_vld=1, with o_score and o_err held stable until i_score_rdy=1, then IDLE.
REQ-017 o_arr_local SHALL equal the latched i_local for the whole job.
REQ-018 o_busy=1 in every state except IDLE.

Reset
REQ-019 i_rst SHALL force IDLE in any state, including mid-STREAM.
REQ-020 i_rst SHALL zero all outputs except o_arr_rst, which is driven to 1 during reset.

Configuration
REQ-021 With SW_CTRL_CYCLE_CNT_EN defined, a 32-bit output o_cycles SHALL count cycles from leaving IDLE to entering DONE, held in DONE.
REQ-022 With SW_CTRL_CYCLE_CNT_EN undefined, o_cycles and its counter SHALL be absent.

Structure
REQ-023 Package sw_pkg SHALL hold SCORE_WIDTH, the nucleotide codes N_A/N_G/N_T/N_C, NEUTRAL=0x400 and the FSM state enum.
REQ-024 Sub-module sw_ctrl_capture SHALL implement the DRAIN high-capture, de-bias and timeout.

Verification (LENGTH=4)
REQ-025 Query AGTC, target AGTC, local -> o_score=20, o_err=0.
REQ-026 Query AAAA, target CCCC, local -> o_score=0.
REQ-027 i_t_vld low for 1 cycle at target character 2 -> o_err=1, o_arr_vld low next cycle.
REQ-028 i_score_rdy held low for 10 cycles -> o_score_vld and o_score stable for those 10 cycles; i_start pulsed in that window is ignored.
REQ-029 i_rst mid-STREAM -> IDLE next cycle; a new job afterwards gives the correct score.
REQ-030 i_tlen=0 -> o_score_vld with o_score=0 immediately after LOAD.
